// File: rtl/contador_rega.sv
// Irrigation countdown timer: BCD MM:SS preset, one-second decrement, valve drive while counting.
// Optional pause input and PAUSE state are built when CONTADOR_REGA_PAUSE_EN is defined.
module contador_rega (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
`ifdef CONTADOR_REGA_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [3:0] preset_us,
    input  logic [3:0] preset_ds,
    input  logic [3:0] preset_um,
    input  logic [3:0] preset_dm,
    output logic [3:0] us,
    output logic [3:0] ds,
    output logic [3:0] um,
    output logic [3:0] dm,
    output logic       valve,
    output logic       done,
    output logic       busy
);

`ifdef CONTADOR_REGA_PAUSE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic [15:0] w_preset;
    logic [15:0] w_dec;
    logic        w_preset_zero;
    logic        w_dec_zero;
    logic        r_valve;
    logic        r_done;
    logic        r_busy;
    logic        w_valve_nxt;
    logic        w_done_nxt;
    logic        w_busy_nxt;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Count is packed {dm, um, ds, us}; borrows ripple us -> ds -> um -> dm.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] u;
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] t;
        u = c[3:0];
        d = c[7:4];
        m = c[11:8];
        t = c[15:12];
        if (u != 4'd0) begin
            u = u - 4'd1;
        end else begin
            u = 4'd9;
            if (d != 4'd0) begin
                d = d - 4'd1;
            end else begin
                d = 4'd5;
                if (m != 4'd0) begin
                    m = m - 4'd1;
                end else begin
                    m = 4'd9;
                    t = t - 4'd1;
                end
            end
        end
        return {t, m, d, u};
    endfunction

    assign w_preset = {clamp_digit(preset_dm, 4'd9), clamp_digit(preset_um, 4'd9),
                       clamp_digit(preset_ds, 4'd5), clamp_digit(preset_us, 4'd9)};
    assign w_preset_zero = (w_preset == 16'd0);
    assign w_dec         = bcd_dec(r_count);
    assign w_dec_zero    = (w_dec == 16'd0);

    // State, count and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= 16'd0;
            r_valve <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_valve <= w_valve_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and next-count; priority is stop > start > pause > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_count_nxt = w_preset;
                    w_state_nxt = w_preset_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_count_nxt = w_preset;
                    w_state_nxt = w_preset_zero ? S_DONE : S_RUN;
`ifdef CONTADOR_REGA_PAUSE_EN
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
`endif
                end else if (tick) begin
                    w_count_nxt = w_dec;
                    w_state_nxt = w_dec_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef CONTADOR_REGA_PAUSE_EN
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_count_nxt = w_preset;
                    w_state_nxt = w_preset_zero ? S_DONE : S_RUN;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_PAUSE;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        w_valve_nxt = (w_state_nxt == S_RUN);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    assign us    = r_count[3:0];
    assign ds    = r_count[7:4];
    assign um    = r_count[11:8];
    assign dm    = r_count[15:12];
    assign valve = r_valve;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

// File: tb/tb_contador_rega.sv
// Self-checking bench for contador_rega: directed scenarios then random traffic vs a seconds-based model.
module tb_contador_rega;

    logic       clk = 1'b0;
    logic       rst_n, tick, start, stop;
    logic [3:0] p_us, p_ds, p_um, p_dm;
    logic [3:0] us, ds, um, dm;
    logic       valve, done, busy;
`ifdef CONTADOR_REGA_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int m_secs  = 0;
    bit m_run   = 1'b0;
    bit m_pause = 1'b0;
    bit m_done  = 1'b0;

    always #5 clk = ~clk;

    contador_rega dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
`ifdef CONTADOR_REGA_PAUSE_EN
        .pause     (pause),
`endif
        .preset_us (p_us),
        .preset_ds (p_ds),
        .preset_um (p_um),
        .preset_dm (p_dm),
        .us        (us),
        .ds        (ds),
        .um        (um),
        .dm        (dm),
        .valve     (valve),
        .done      (done),
        .busy      (busy)
    );

    function automatic int clampv(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int preset_secs();
        int mins;
        int secs;
        mins = clampv(int'(p_dm), 9) * 10 + clampv(int'(p_um), 9);
        secs = clampv(int'(p_ds), 5) * 10 + clampv(int'(p_us), 9);
        return mins * 60 + secs;
    endfunction

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: the count is a plain number of seconds.
    task automatic model_step();
        int p;
        p = preset_secs();
        if (!rst_n) begin
            m_secs = 0; m_run = 1'b0; m_pause = 1'b0; m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_run || m_pause) begin
            if (stop) begin
                m_run = 1'b0; m_pause = 1'b0;
            end else if (start) begin
                m_secs = p; m_pause = 1'b0; m_run = (p != 0); m_done = (p == 0);
`ifdef CONTADOR_REGA_PAUSE_EN
            end else if (m_run && pause) begin
                m_run = 1'b0; m_pause = 1'b1;
            end else if (m_pause && !pause) begin
                m_pause = 1'b0; m_run = 1'b1;
`endif
            end else if (m_run && tick) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_run = 1'b0; m_done = 1'b1;
                end
            end
        end else if (start && !stop) begin
            m_secs = p; m_run = (p != 0); m_done = (p == 0);
        end
    endtask

    task automatic check_all(string lbl);
        chk({lbl, ".us"},    16'(us), 16'(m_secs % 10));
        chk({lbl, ".ds"},    16'(ds), 16'((m_secs % 60) / 10));
        chk({lbl, ".um"},    16'(um), 16'((m_secs / 60) % 10));
        chk({lbl, ".dm"},    16'(dm), 16'(m_secs / 600));
        chk({lbl, ".valve"}, 16'(valve), 16'(m_run));
        chk({lbl, ".done"},  16'(done), 16'(m_done));
        chk({lbl, ".busy"},  16'(busy), 16'(m_run || m_pause || m_done));
    endtask

    task automatic step(string lbl, bit r, bit s, bit sp, bit t);
        rst_n = r; start = s; stop = sp; tick = t;
        @(posedge clk);
        model_step();
        #1;
        check_all(lbl);
    endtask

    task automatic set_preset(logic [3:0] a_dm, logic [3:0] a_um, logic [3:0] a_ds, logic [3:0] a_us);
        p_dm = a_dm; p_um = a_um; p_ds = a_ds; p_us = a_us;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        step("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_busy", 16'(busy), 16'd0);
        step("idle", 1'b1, 1'b0, 1'b0, 1'b1);

        // 00:03 countdown to done
        set_preset(4'd0, 4'd0, 4'd0, 4'd3);
        step("r28_start", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("r28_valve_on", 16'(valve), 16'd1);
        step("r28_t1", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r28_us2", 16'(us), 16'd2);
        step("r28_t2", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r28_us1", 16'(us), 16'd1);
        step("r28_t3", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r28_done", 16'(done), 16'd1);
        chk("r28_valve_off", 16'(valve), 16'd0);
        step("r28_idle", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r28_done_pulse", 16'(done), 16'd0);

        // 10:00 borrows through every digit
        set_preset(4'd1, 4'd0, 4'd0, 4'd0);
        step("r29_start", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r29_t1", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r29_0959", {dm, um, ds, us}, 16'h0959);
        step("r29_t2", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r29_0958", {dm, um, ds, us}, 16'h0958);
        step("r29_stop", 1'b1, 1'b0, 1'b1, 1'b0);

        // zero preset goes straight to done
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        step("r30_start", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("r30_done", 16'(done), 16'd1);
        chk("r30_valve", 16'(valve), 16'd0);
        step("r30_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // clamping, start+tick same cycle
        set_preset(4'd2, 4'hC, 4'd7, 4'hF);
        step("r31_start", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("r31_2959", {dm, um, ds, us}, 16'h2959);
        step("r31_restart", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("r31_reload", {dm, um, ds, us}, 16'h2959);
        step("r31_stopstart", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("r31_stop_wins", 16'(busy), 16'd0);

        // stop mid-run, then reset mid-run
        set_preset(4'd0, 4'd5, 4'd3, 4'd1);
        step("r32_start", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r32_t", 1'b1, 1'b0, 1'b0, 1'b1);
        step("r32_stop", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("r32_hold", {dm, um, ds, us}, 16'h0530);
        chk("r32_valve", 16'(valve), 16'd0);
        chk("r32_nodone", 16'(done), 16'd0);
        step("r32_start2", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r32_t2", 1'b1, 1'b0, 1'b0, 1'b1);
        step("r32_rst", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("r32_zero", {dm, um, ds, us}, 16'h0000);
        chk("r32_busy", 16'(busy), 16'd0);

`ifdef CONTADOR_REGA_PAUSE_EN
        // pause freezes the count and closes the valve
        set_preset(4'd0, 4'd1, 4'd0, 4'd1);
        step("r33_start", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r33_t", 1'b1, 1'b0, 1'b0, 1'b1);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) step("r33_p", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r33_hold", {dm, um, ds, us}, 16'h0100);
        chk("r33_valve", 16'(valve), 16'd0);
        pause = 1'b0;
        step("r33_rel", 1'b1, 1'b0, 1'b0, 1'b0);
        step("r33_t2", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("r33_0059", {dm, um, ds, us}, 16'h0059);
`endif

        // random traffic, short presets so runs often complete
        for (int i = 0; i < 3000; i++) begin
            set_preset(($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                       ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                       4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
`ifdef CONTADOR_REGA_PAUSE_EN
            if ($urandom_range(0, 15) == 0) pause = ~pause;
`endif
            step("rnd", $urandom_range(0, 199) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
